// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage with a one-entry skid buffer and IF/ID register for the 16-bit CPU.
// Optional perf counters under FETCH_PERF_COUNTERS_EN.
module if_id_fetch_stage #(
    parameter int                  PC_WIDTH  = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [15:0]         NOP_INSTR = 16'h0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                branchTaken,
    input  logic [PC_WIDTH-1:0] branchTarget,
    output logic                imemReq,
    output logic [PC_WIDTH-1:0] imemAddr,
    input  logic                imemValid,
    input  logic [15:0]         imemData,
    output logic [15:0]         instruction,
    output logic [PC_WIDTH-1:0] pcOut,
    output logic [PC_WIDTH-1:0] pcPlus2,
    output logic                idValid
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [15:0]         fetchCount,
    output logic [15:0]         bubbleCount
`endif
);

    typedef enum logic {FETCH = 1'b0, BUFFERED = 1'b1} state_t;

    state_t              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] buf_pc_q;
    logic [15:0]         buf_instr_q;
    logic [15:0]         instr_q;
    logic [PC_WIDTH-1:0] pc_out_q;
    logic [PC_WIDTH-1:0] pc_plus2_q;
    logic                id_valid_q;
    logic                req_q;

    logic [PC_WIDTH-1:0] pc_inc_d;
    logic [PC_WIDTH-1:0] buf_inc_d;
    logic [PC_WIDTH-1:0] redirect_d;
    logic                redirect;
    logic                unused_tgt_lsb;

    assign pc_inc_d       = pc_q + PC_WIDTH'(2);
    assign buf_inc_d      = buf_pc_q + PC_WIDTH'(2);
    assign redirect_d     = {branchTarget[PC_WIDTH-1:1], 1'b0};
    assign redirect       = flush | branchTaken;
    assign unused_tgt_lsb = branchTarget[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            buf_pc_q    <= '0;
            buf_instr_q <= NOP_INSTR;
            instr_q     <= NOP_INSTR;
            pc_out_q    <= '0;
            pc_plus2_q  <= '0;
            id_valid_q  <= 1'b0;
            req_q       <= 1'b0;
        end else if (redirect) begin
            instr_q    <= NOP_INSTR;
            id_valid_q <= 1'b0;
            state_q    <= FETCH;
            req_q      <= 1'b1;
            if (branchTaken) pc_q <= redirect_d;
        end else if (state_q == BUFFERED) begin
            if (!stall) begin
                instr_q    <= buf_instr_q;
                pc_out_q   <= buf_pc_q;
                pc_plus2_q <= buf_inc_d;
                id_valid_q <= 1'b1;
                state_q    <= FETCH;
                req_q      <= 1'b1;
            end
        end else if (!req_q) begin
            // First cycle out of reset: no request was outstanding, so any response is stale.
            req_q <= 1'b1;
        end else if (imemValid) begin
            pc_q <= pc_inc_d;
            if (stall) begin
                buf_instr_q <= imemData;
                buf_pc_q    <= pc_q;
                state_q     <= BUFFERED;
                req_q       <= 1'b0;
            end else begin
                instr_q    <= imemData;
                pc_out_q   <= pc_q;
                pc_plus2_q <= pc_inc_d;
                id_valid_q <= 1'b1;
            end
        end else if (!stall) begin
            instr_q    <= NOP_INSTR;
            id_valid_q <= 1'b0;
        end
    end

    assign imemReq     = req_q;
    assign imemAddr    = pc_q;
    assign instruction = instr_q;
    assign pcOut       = pc_out_q;
    assign pcPlus2     = pc_plus2_q;
    assign idValid     = id_valid_q;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [15:0] fetch_cnt_q;
    logic [15:0] bubble_cnt_q;
    logic        fetch_inc;
    logic        bubble_inc;

    assign fetch_inc  = !redirect && !stall &&
                        ((state_q == BUFFERED) || (req_q && imemValid));
    assign bubble_inc = !stall &&
                        (redirect || ((state_q == FETCH) && req_q && !imemValid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (fetch_inc)  fetch_cnt_q  <= fetch_cnt_q + 16'd1;
            if (bubble_inc) bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign fetchCount  = fetch_cnt_q;
    assign bubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed vector bench for if_id_fetch_stage: table of per-edge stimulus and expected IF/ID state.
module tb_if_id_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branchTaken = 1'b0;
    logic [15:0] branchTarget = 16'h0000;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic        imemValid = 1'b0;
    logic [15:0] imemData = 16'h0000;
    logic [15:0] instruction;
    logic [15:0] pcOut;
    logic [15:0] pcPlus2;
    logic        idValid;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [15:0] fetchCount;
    logic [15:0] bubbleCount;
`endif

    int checks = 0;
    int passed = 0;

    if_id_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemValid(imemValid),
        .imemData(imemData), .instruction(instruction), .pcOut(pcOut),
        .pcPlus2(pcPlus2), .idValid(idValid)
`ifdef FETCH_PERF_COUNTERS_EN
        , .fetchCount(fetchCount), .bubbleCount(bubbleCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        fl;
        logic        br;
        logic [15:0] tgt;
        logic        vld;
        logic [15:0] dat;
        logic [15:0] e_instr;
        logic [15:0] e_pc;
        logic [15:0] e_pc2;
        logic        e_idv;
        logic        e_req;
        logic [15:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic fl, logic br, logic [15:0] tgt,
                                logic vld, logic [15:0] dat, logic [15:0] e_instr,
                                logic [15:0] e_pc, logic [15:0] e_pc2, logic e_idv,
                                logic e_req, logic [15:0] e_addr);
        vec_t v;
        v.st = st; v.fl = fl; v.br = br; v.tgt = tgt; v.vld = vld; v.dat = dat;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_pc2 = e_pc2; v.e_idv = e_idv;
        v.e_req = e_req; v.e_addr = e_addr;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s [vec %0d]: got %h, expected %h", name, idx, act, exp);
    endtask

    // pcOut/pcPlus2 are only meaningful while IF/ID holds a real instruction.
    task automatic check_outputs(input int idx, input logic [15:0] e_instr,
                                 input logic [15:0] e_pc, input logic [15:0] e_pc2,
                                 input logic e_idv, input logic e_req,
                                 input logic [15:0] e_addr);
        check("instruction", idx, instruction, e_instr);
        check("idValid", idx, {15'd0, idValid}, {15'd0, e_idv});
        check("imemReq", idx, {15'd0, imemReq}, {15'd0, e_req});
        check("imemAddr", idx, imemAddr, e_addr);
        if (e_idv) begin
            check("pcOut", idx, pcOut, e_pc);
            check("pcPlus2", idx, pcPlus2, e_pc2);
        end
    endtask

    initial begin
        //            st fl br tgt       vld dat       instr     pc        pc2       idv req addr
        vecs.push_back(mk(0,0,0,16'h0000, 0,16'h0000, 16'h0000,16'h0000,16'h0000, 0,1,16'h0000)); // startup
        vecs.push_back(mk(0,0,0,16'h0000, 1,16'hC001, 16'hC001,16'h0000,16'h0002, 1,1,16'h0002));
        vecs.push_back(mk(0,0,0,16'h0000, 1,16'hA123, 16'hA123,16'h0002,16'h0004, 1,1,16'h0004));
        vecs.push_back(mk(0,0,0,16'h0000, 1,16'hB598, 16'hB598,16'h0004,16'h0006, 1,1,16'h0006));
        vecs.push_back(mk(0,0,0,16'h0000, 0,16'h0000, 16'h0000,16'h0000,16'h0000, 0,1,16'h0006)); // 3-cycle mem
        vecs.push_back(mk(0,0,0,16'h0000, 0,16'h0000, 16'h0000,16'h0000,16'h0000, 0,1,16'h0006));
        vecs.push_back(mk(0,0,0,16'h0000, 1,16'h1111, 16'h1111,16'h0006,16'h0008, 1,1,16'h0008));
        vecs.push_back(mk(0,0,0,16'h0000, 0,16'h0000, 16'h0000,16'h0000,16'h0000, 0,1,16'h0008));
        vecs.push_back(mk(0,0,0,16'h0000, 0,16'h0000, 16'h0000,16'h0000,16'h0000, 0,1,16'h0008));
        vecs.push_back(mk(0,0,0,16'h0000, 1,16'h2222, 16'h2222,16'h0008,16'h000A, 1,1,16'h000A));
        vecs.push_back(mk(0,0,0,16'h0000, 1,16'h3333, 16'h3333,16'h000A,16'h000C, 1,1,16'h000C));
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'hD698, 16'h3333,16'h000A,16'h000C, 1,0,16'h000E)); // skid capture
        vecs.push_back(mk(1,0,0,16'h0000, 0,16'h0000, 16'h3333,16'h000A,16'h000C, 1,0,16'h000E));
        vecs.push_back(mk(1,0,0,16'h0000, 0,16'h0000, 16'h3333,16'h000A,16'h000C, 1,0,16'h000E));
        vecs.push_back(mk(1,0,0,16'h0000, 0,16'h0000, 16'h3333,16'h000A,16'h000C, 1,0,16'h000E));
        vecs.push_back(mk(0,0,0,16'h0000, 0,16'h0000, 16'hD698,16'h000C,16'h000E, 1,1,16'h000E)); // drain buffer
        vecs.push_back(mk(0,0,0,16'h0000, 1,16'h4444, 16'h4444,16'h000E,16'h0010, 1,1,16'h0010));
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h5555, 16'h4444,16'h000E,16'h0010, 1,0,16'h0012)); // fill buffer
        vecs.push_back(mk(1,0,1,16'h0041, 0,16'h0000, 16'h0000,16'h0000,16'h0000, 0,1,16'h0040)); // branch over stall
        vecs.push_back(mk(0,0,0,16'h0000, 1,16'h6666, 16'h6666,16'h0040,16'h0042, 1,1,16'h0042));
        vecs.push_back(mk(0,0,1,16'hFFFF, 0,16'h0000, 16'h0000,16'h0000,16'h0000, 0,1,16'hFFFE));
        vecs.push_back(mk(0,0,0,16'h0000, 1,16'h5123, 16'h5123,16'hFFFE,16'h0000, 1,1,16'h0000)); // wrap
        vecs.push_back(mk(0,0,0,16'h0000, 1,16'h7777, 16'h7777,16'h0000,16'h0002, 1,1,16'h0002));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'h8888, 16'h0000,16'h0000,16'h0000, 0,1,16'h0002)); // flush over stall
        vecs.push_back(mk(0,0,0,16'h0000, 1,16'h9999, 16'h9999,16'h0002,16'h0004, 1,1,16'h0004));
        vecs.push_back(mk(1,0,0,16'h0000, 0,16'h0000, 16'h9999,16'h0002,16'h0004, 1,1,16'h0004)); // stall, no data

        #2;
        check_outputs(-1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        check("pcOut_rst", -1, pcOut, 16'h0000);
        check("pcPlus2_rst", -1, pcPlus2, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            stall = vecs[i].st; flush = vecs[i].fl; branchTaken = vecs[i].br;
            branchTarget = vecs[i].tgt; imemValid = vecs[i].vld; imemData = vecs[i].dat;
            @(posedge clk);
            #1;
            check_outputs(i, vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_pc2,
                          vecs[i].e_idv, vecs[i].e_req, vecs[i].e_addr);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a stall with the buffer full.
        stall = 1'b1; flush = 1'b0; branchTaken = 1'b0; imemValid = 1'b1; imemData = 16'hAAAA;
        @(posedge clk);
        #1;
        check("imemReq_buffered", 100, {15'd0, imemReq}, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs(101, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        check("pcOut_async_rst", 101, pcOut, 16'h0000);
        check("pcPlus2_async_rst", 101, pcPlus2, 16'h0000);
`ifdef FETCH_PERF_COUNTERS_EN
        check("fetchCount_rst", 101, fetchCount, 16'h0000);
        check("bubbleCount_rst", 101, bubbleCount, 16'h0000);
`endif
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0; imemValid = 1'b1; imemData = 16'hABCD;
        @(posedge clk);
        #1;
        check_outputs(102, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000); // stale response ignored
        @(negedge clk);
        imemData = 16'h1234;
        @(posedge clk);
        #1;
        check_outputs(103, 16'h1234, 16'h0000, 16'h0002, 1'b1, 1'b1, 16'h0002);
`ifdef FETCH_PERF_COUNTERS_EN
        check("fetchCount", 103, fetchCount, 16'h0001);
        check("bubbleCount", 103, bubbleCount, 16'h0000);
`endif
        @(negedge clk);
        imemValid = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
